// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the single-port work RAM between the game CPU and the hiscore engine
// Ports:
//   clk, reset                    core clock, synchronous active-high reset
//   vblank                        core vertical blank (clk-synchronous)
//   hs_req, hs_address,           hiscore request level, address, write data, write strobe
//   hs_data_in, hs_write
//   hs_data_out                   RAM read data to hiscore (ram_dout passthrough)
//   hs_grant, pause_cpu           hiscore owns RAM / CPU halt request
//   cpu_addr, cpu_din, cpu_we     CPU RAM port
//   ram_addr, ram_din, ram_we     muxed RAM port
//   ram_dout                      RAM read data
module hs_ram_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int SETTLE   = 4,
    parameter int MAX_HOLD = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_grant,
    output logic          pause_cpu,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_GRANT, S_RELEASE} state_t;
    state_t        state_q;
    logic          pause_q, grant_q, vbl_q, rearm_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hold_q;
    logic          vbl_rise;
    assign vbl_rise = vblank & ~vbl_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pause_q <= 1'b0;
            grant_q <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
            vbl_q   <= 1'b0;
            rearm_q <= 1'b1;
        end else begin
            vbl_q <= vblank;
            if (!hs_req) rearm_q <= 1'b1;
            case (state_q)
                S_IDLE: if (hs_req && rearm_q) state_q <= S_WAIT;
                S_WAIT: begin
                    if (!hs_req) state_q <= S_IDLE;
                    else if (vbl_rise) begin
                        state_q <= S_SETTLE;
                        pause_q <= 1'b1;
                        cnt_q   <= CW'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (!hs_req) state_q <= S_RELEASE;
                    else if (cnt_q == '0) begin
                        state_q <= S_GRANT;
                        grant_q <= 1'b1;
                        hold_q  <= '0;
                    end else cnt_q <= cnt_q - CW'(1);
                end
                S_GRANT: begin
                    // a still-held request at the hold limit is a forced drop: disarm until hs_req falls
                    if (!hs_req || hold_q == HW'(MAX_HOLD - 1)) begin
                        state_q <= S_RELEASE;
                        grant_q <= 1'b0;
                        rearm_q <= !hs_req;
                    end else hold_q <= hold_q + HW'(1);
                end
                // pause held one extra cycle so no CPU write lands right after the hiscore access
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    pause_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign hs_grant    = grant_q;
    assign pause_cpu   = pause_q;
    assign ram_addr    = grant_q ? hs_address : cpu_addr;
    assign ram_din     = grant_q ? hs_data_in : cpu_din;
    assign ram_we      = grant_q ? hs_write : (cpu_we & ~pause_q);
    assign hs_data_out = ram_dout;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: scoreboard bench for hs_ram_arbiter with SETTLE=4, MAX_HOLD=16
module tb_hs_ram_arbiter;
    localparam logic [15:0] HA = 16'h4380;
    localparam logic [15:0] CA = 16'h1234;
    localparam logic [7:0]  HD = 8'hA5;
    localparam logic [7:0]  CD = 8'h5A;
    localparam logic [7:0]  RD = 8'hC3;
    logic        clk = 1'b0;
    logic        reset, vblank, hs_req, hs_write, cpu_we;
    logic [15:0] hs_address, cpu_addr, ram_addr;
    logic [7:0]  hs_data_in, cpu_din, ram_din, ram_dout, hs_data_out;
    logic        hs_grant, pause_cpu, ram_we;
    int          checks = 0;
    int          passes = 0;
    logic [34:0] sbq[$];
    logic [34:0] e;

    hs_ram_arbiter #(.AW(16), .DW(8), .SETTLE(4), .MAX_HOLD(16)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .hs_req(hs_req),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
        .hs_data_out(hs_data_out), .hs_grant(hs_grant), .pause_cpu(pause_cpu),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] ev(input logic g, input logic p, input logic we);
        return {g, p, we, g ? HA : CA, g ? HD : CD, RD};
    endfunction

    function automatic logic [34:0] obs();
        return {hs_grant, pause_cpu, ram_we, ram_addr, ram_din, hs_data_out};
    endfunction

    task automatic idle_pre();
        vblank = 1'b0; hs_req = 1'b0; hs_write = 1'b0; cpu_we = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_we = 1'b1;
        sbq.push_back(ev(1'b0, 1'b0, 1'b1));
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs() !== e) $display("FAIL reset: got %h expected %h", obs(), e);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int r = 2;
        idle_pre();
        for (int k = 0; k <= r + 23; k++) begin
            hs_req = k < r + 20;
            vblank = k >= r;
            sbq.push_back(ev(k >= r + 4 && k < r + 20, k >= r && k <= r + 20, 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL basic k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_write_mask();
        int r = 2;
        logic g, p;
        idle_pre();
        cpu_we = 1'b1;
        for (int k = 0; k <= r + 12; k++) begin
            hs_req = k < r + 8;
            vblank = k >= r;
            hs_write = k[0];
            g = k >= r + 4 && k < r + 8;
            p = k >= r && k <= r + 8;
            sbq.push_back(ev(g, p, g ? hs_write : ~p));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL write_mask k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_mid_vblank();
        int r = 9;
        idle_pre();
        vblank = 1'b1;
        tick(); tick();
        for (int k = 0; k <= r + 8; k++) begin
            hs_req = k < r + 6;
            vblank = k < 6 || k >= r;
            hs_write = k < 6 ? k[0] : 1'b0;
            sbq.push_back(ev(k >= r + 4 && k < r + 6, k >= r && k <= r + 6, 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL mid_vblank k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_hold_limit();
        int r = 2;
        logic g, p;
        idle_pre();
        for (int k = 0; k <= r + 57; k++) begin
            hs_req = k != r + 45 && k < r + 54;
            vblank = k >= r && ((k - r) % 8) < 4;
            g = (k >= r + 4 && k <= r + 19) || (k >= r + 52 && k < r + 54);
            p = (k >= r && k <= r + 20) || (k >= r + 48 && k <= r + 54);
            sbq.push_back(ev(g, p, 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL hold_limit k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_abort_settle();
        int r = 2;
        logic p;
        idle_pre();
        cpu_we = 1'b1;
        for (int k = 0; k <= r + 8; k++) begin
            hs_req = k < r + 2;
            vblank = k >= r;
            p = k >= r && k <= r + 2;
            sbq.push_back(ev(1'b0, p, ~p));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL abort_settle k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_simul_drop();
        idle_pre();
        for (int k = 0; k <= 6; k++) begin
            hs_req = k < 2;
            vblank = k >= 2;
            sbq.push_back(ev(1'b0, 1'b0, 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL simul_drop k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_grant();
        int r = 2;
        idle_pre();
        cpu_we = 1'b1;
        for (int k = 0; k <= r + 10; k++) begin
            hs_req = 1'b1;
            vblank = k >= r;
            reset = k == r + 6;
            sbq.push_back(k < r + 6 ? ev(k >= r + 4, k >= r, k < r) : ev(1'b0, 1'b0, 1'b1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs() !== e) $display("FAIL reset_mid_grant k=%0d: got %h expected %h", k, obs(), e);
            else passes++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vblank = 1'b0; hs_req = 1'b0; hs_write = 1'b0; cpu_we = 1'b0;
        hs_address = HA; cpu_addr = CA; hs_data_in = HD; cpu_din = CD; ram_dout = RD;
        tick();
        test_reset();
        test_basic();
        test_write_mask();
        test_mid_vblank();
        test_hold_limit();
        test_abort_settle();
        test_simul_drop();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the core's single-port work RAM between the game CPU and the hiscore engine.
- On a hiscore request it waits for the next vblank rising edge, then asserts pause_cpu and lets the CPU settle.
- It then grants the hiscore port exclusive RAM access and releases the pause when the request drops or a hold limit expires.
- Sits between the hiscore module, the pause system and the core's RAM mux, in clk domain.

Parameters:
AW, 16, RAM address width.
DW, 8, RAM data width.
SETTLE, 4, cycles between pause_cpu assertion and hs_grant (1..255).
MAX_HOLD, 1023, maximum cycles hs_grant may stay high per request (1..65535).

Ports:
clk  in  1  system clock (core clock).
reset  in  1  synchronous, active-high reset.
vblank  in  1  core vertical blank, clk-synchronous.
hs_req  in  1  level request from hiscore engine.
hs_address  in  AW  hiscore RAM address.
hs_data_in  in  DW  hiscore write data.
hs_write  in  1  hiscore write strobe, honoured only while hs_grant=1.
hs_data_out  out  DW  RAM read data to hiscore (ram_dout passthrough).
hs_grant  out  1  hiscore owns RAM.
pause_cpu  out  1  CPU halt request to core (OR'd externally with user pause).
cpu_addr  in  AW  CPU RAM address.
cpu_din  in  DW  CPU write data.
cpu_we  in  1  CPU write strobe.
ram_addr  out  AW  to RAM.
ram_din  out  DW  to RAM.
ram_we  out  1  to RAM.
ram_dout  in  DW  from RAM.

Behaviour:
- The interface is fixed as one clock, clk. reset is synchronous and active-high.
- Reset, also mid-operation, forces state=IDLE, pause_cpu=0, hs_grant=0, counters=0, vblank_d=0 and rearm=1 on the next edge. The RAM mux returns to the CPU immediately.
- vbl_rise = vblank & ~vblank_d. vblank_d is registered every cycle.
- FSM, all outputs registered:
  - IDLE: if hs_req & rearm, go to WAIT_VBL. A request arriving while vblank is already high waits for the next rising edge.
  - WAIT_VBL: if hs_req=0, return to IDLE. On vbl_rise, go to SETTLE, set pause_cpu=1 and load cnt=SETTLE-1.
  - SETTLE: decrement cnt. Go to GRANT when cnt=0 (hs_grant=1 exactly SETTLE cycles after pause_cpu rises). Clear hold counter.
    - If hs_req drops during SETTLE, go to RELEASE without granting.
  - GRANT: hold counter increments each cycle.
    - If hs_req=0, go to RELEASE.
    - If the counter reaches MAX_HOLD-1, go to RELEASE and set rearm=0 (forced drop). hs_grant is high for at most MAX_HOLD cycles.
  - RELEASE: hs_grant=0 and pause_cpu stays 1 for this one cycle (write hazard guard). Then go to IDLE with pause_cpu=0.
- rearm is set back to 1 in any cycle where hs_req=0. After a forced drop, the requester must deassert hs_req before it is served again.
- Mux (combinational on registered hs_grant):
  - ram_addr = hs_grant ? hs_address : cpu_addr.
  - ram_din = hs_grant ? hs_data_in : cpu_din.
  - ram_we = hs_grant ? hs_write : (cpu_we & ~pause_cpu).
  - CPU writes are masked in every cycle pause_cpu=1. hs_write is ignored whenever hs_grant=0.
- hs_data_out = ram_dout at all times. RAM read latency is the requester's concern.
- Simultaneous events:
  - hs_req falling in the same cycle as vbl_rise in WAIT_VBL gives IDLE; no pause.
  - hs_req falling on the cycle the hold limit hits gives RELEASE with rearm=1.
- Counter widths are sized from SETTLE and MAX_HOLD; no wrap is possible.

Test Plan:
- Reset mid-GRANT (SETTLE=4): assert reset for 1 cycle during GRANT -> next cycle hs_grant=0, pause_cpu=0, ram_addr=cpu_addr.
- Basic access (SETTLE=4): hs_req=1 at vblank=0, vblank rises at cycle T -> pause_cpu=1 at T+1, hs_grant=1 at T+5, ram_addr=hs_address. Drop hs_req at T+20 -> hs_grant=0 at T+21, pause_cpu=0 at T+22.
- Mid-vblank request: hs_req rises while vblank=1 -> no pause until vblank falls and rises again; hs_write pulses while waiting -> ram_we=0.
- Write masking: cpu_we=1 throughout, hs_write=1 with hs_data_in=8'hA5 at addr 16'h4380 during GRANT -> ram_we follows hs_write, ram_din=8'hA5; ram_we=0 in SETTLE and RELEASE cycles despite cpu_we.
- Hold limit (MAX_HOLD=16): hs_req held high -> hs_grant high exactly 16 cycles, then RELEASE. Keep hs_req high across 3 more vblank edges -> no re-grant. Drop hs_req 1 cycle and raise it -> served at next vbl_rise.
- Abort in SETTLE: hs_req drops 2 cycles after pause_cpu rises -> hs_grant never asserts; pause_cpu falls 2 cycles later (SETTLE->RELEASE->IDLE).
